// File: rtl/instr_encoder.sv
// Packs decoded MIPS fields into 32-bit words and writes them to instruction memory
// at an auto-incrementing address. Optional delay-slot NOP insertion: ENCODER_DELAY_SLOT_NOP_EN.
module instr_encoder #(
  parameter int ADDR_W     = 8,
  parameter int START_ADDR = 0
) (
  input  logic              i_clk,
  input  logic              i_rst_n,
  input  logic              i_restart,
  input  logic              i_valid,
  output logic              o_ready,
  input  logic [5:0]        i_opcode,
  input  logic [4:0]        i_rs,
  input  logic [4:0]        i_rt,
  input  logic [4:0]        i_rd,
  input  logic [4:0]        i_shamt,
  input  logic [5:0]        i_funct,
  input  logic [15:0]       i_imm,
  input  logic [25:0]       i_target,
  output logic              o_mem_we,
  output logic [ADDR_W-1:0] o_mem_addr,
  output logic [31:0]       o_mem_wdata,
  output logic [ADDR_W:0]   o_count,
  output logic              o_err,
  output logic              o_full
);

  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] WRITE = 2'd1;
  localparam logic [1:0] FULL  = 2'd2;
`ifdef ENCODER_DELAY_SLOT_NOP_EN
  localparam logic [1:0] NOP   = 2'd3;
`endif

  localparam logic [ADDR_W-1:0] startAddr = ADDR_W'(START_ADDR);
  localparam logic [ADDR_W-1:0] lastAddr  = {ADDR_W{1'b1}};

  logic [1:0]        state;
  logic [ADDR_W-1:0] addr;
  logic [ADDR_W:0]   count;
  logic              err;
  logic              memWe;
  logic [31:0]       memWdata;

  function automatic logic isLegal(input logic [5:0] op);
    case (op)
      6'h00, 6'h08, 6'h09, 6'h0D, 6'h0E, 6'h0F,
      6'h23, 6'h2B, 6'h04, 6'h05, 6'h02: isLegal = 1'b1;
      default:                            isLegal = 1'b0;
    endcase
  endfunction

`ifdef ENCODER_DELAY_SLOT_NOP_EN
  function automatic logic isBranch(input logic [5:0] op);
    isBranch = (op == 6'h04) || (op == 6'h05) || (op == 6'h02);
  endfunction
`endif

  function automatic logic [31:0] encode(
    input logic [5:0]  op,
    input logic [4:0]  rs,
    input logic [4:0]  rt,
    input logic [4:0]  rd,
    input logic [4:0]  shamt,
    input logic [5:0]  funct,
    input logic [15:0] imm,
    input logic [25:0] target
  );
    case (op)
      6'h00:   encode = {op, rs, rt, rd, shamt, funct};
      6'h02:   encode = {op, target};
      6'h0F:   encode = {op, 5'd0, rt, imm};  // LUI has no source register
      default: encode = {op, rs, rt, imm};
    endcase
  endfunction

  // NOTE: all state below is sequential and uses non-blocking assignments so every
  // register samples the pre-edge values regardless of statement order.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state    <= IDLE;
      addr     <= startAddr;
      count    <= '0;
      err      <= 1'b0;
      memWe    <= 1'b0;
      memWdata <= '0;
    end else begin
      case (state)
        IDLE: begin
          memWe <= 1'b0;
          if (i_restart) begin
            addr  <= startAddr;
            count <= '0;
            err   <= 1'b0;
          end else if (i_valid) begin
            if (isLegal(i_opcode)) begin
              memWdata <= encode(i_opcode, i_rs, i_rt, i_rd, i_shamt, i_funct, i_imm, i_target);
              memWe    <= 1'b1;
              state    <= WRITE;
            end else begin
              err <= 1'b1;
            end
          end
        end

        WRITE: begin
          // The write strobe is already on the port this cycle; restart only affects what follows.
          if (i_restart) begin
            addr  <= startAddr;
            count <= '0;
            err   <= 1'b0;
            memWe <= 1'b0;
            state <= IDLE;
          end else begin
            count <= count + 1'b1;
            if (addr == lastAddr) begin
              memWe <= 1'b0;
              state <= FULL;
            end else begin
              addr <= addr + 1'b1;
`ifdef ENCODER_DELAY_SLOT_NOP_EN
              if (isBranch(memWdata[31:26])) begin
                memWe    <= 1'b1;
                memWdata <= '0;
                state    <= NOP;
              end else begin
                memWe <= 1'b0;
                state <= IDLE;
              end
`else
              memWe <= 1'b0;
              state <= IDLE;
`endif
            end
          end
        end

`ifdef ENCODER_DELAY_SLOT_NOP_EN
        NOP: begin
          memWe <= 1'b0;
          if (i_restart) begin
            addr  <= startAddr;
            count <= '0;
            err   <= 1'b0;
            state <= IDLE;
          end else begin
            count <= count + 1'b1;
            if (addr == lastAddr) begin
              state <= FULL;
            end else begin
              addr  <= addr + 1'b1;
              state <= IDLE;
            end
          end
        end
`endif

        FULL: begin
          memWe <= 1'b0;
          if (i_restart) begin
            addr  <= startAddr;
            count <= '0;
            err   <= 1'b0;
            state <= IDLE;
          end
        end

        default: begin
          memWe <= 1'b0;
          state <= IDLE;
        end
      endcase
    end
  end

  assign o_ready     = (state == IDLE);
  assign o_full      = (state == FULL);
  assign o_mem_we    = memWe;
  assign o_mem_addr  = addr;
  assign o_mem_wdata = memWdata;
  assign o_count     = count;
  assign o_err       = err;

endmodule
